// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared constants for the instruction-memory loader: IMEM geometry,
//   loader FSM state encodings, frame constants and the length check.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int ADDR_W         = 6;   // IMEM word-address width
  localparam int DEPTH          = 64;  // IMEM depth in words = max payload length
  localparam int DATA_W         = 32;  // instruction word width
  localparam int BYTES_PER_WORD = 4;
  localparam int WCNT_W         = 7;   // wide enough to hold DEPTH itself

  // Canonical RISC-V no-op (addi x0,x0,0), used by software to pad images.
  localparam logic [DATA_W-1:0] NOP_WORD = 32'h00000013;

  localparam logic [7:0] MAX_LEN = 8'(DEPTH);

  // Loader FSM encodings.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  // A header byte is a usable word count only if 1 <= n <= DEPTH.
  function automatic logic len_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= MAX_LEN);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_word_assembler
//   Packs a stream of bytes into little-endian 32-bit words. The k-th byte of
//   a word lands in bits [8k+7:8k]. The completed word is registered and
//   flagged with a one-cycle word_valid pulse on the cycle after its 4th byte.
// Ports
//   clk, rst    clock, synchronous active-high reset
//   clear       restart assembly at byte 0 (new frame)
//   byte_valid  byte_in is consumed this cycle
//   byte_in     stream byte
//   last_byte   combinational: the consumed byte completes a word
//   word_valid  one-cycle pulse, word holds a fresh completed word
//   word        last completed word
// -----------------------------------------------------------------------------
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              last_byte,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  logic [1:0]        cnt_q,   cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [DATA_W-1:0] word_q,  word_d;
  logic              word_valid_q, word_valid_d;

  assign last_byte = byte_valid && (cnt_q == 2'd3);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid) begin
      // Shift right, newest byte on top: after three bytes the earliest one
      // sits in [7:0], so the 4th byte simply caps the word.
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_in, shift_q[23:8]};
      if (cnt_q == 2'd3) begin
        word_d       = {byte_in, shift_q};
        word_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 2'd0;
      shift_q      <= 24'd0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Write side of the instruction memory. Receives a framed byte stream
//   [N][4*N payload bytes, LSB first][CHK = XOR of payload], writes N words to
//   IMEM addresses 0..N-1 and holds the core while loading.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         1-cycle pulse, begins a frame (ignored while mid-frame)
//   in_data/in_valid/in_ready   byte stream handshake
//   mem_we/mem_addr/mem_wdata   IMEM write port, one pulse per word
//   cpu_hold      core held while loading or after an error
//   done          frame loaded and checksum matched
//   error         bad length or checksum mismatch
//   words_loaded  words written in the current/last frame
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [6:0]        words_loaded
);

  logic [2:0]        state_q, state_d;
  logic [WCNT_W-1:0] len_q,   len_d;
  logic [WCNT_W-1:0] words_q, words_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [7:0]        xor_q,   xor_d;

  logic accept;
  logic asm_clear;
  logic asm_byte_valid;
  logic asm_last_byte;

  assign in_ready = (state_q == S_HDR) || (state_q == S_PAYLOAD) ||
                    (state_q == S_CHK);
  assign accept   = in_valid && in_ready;
  assign asm_byte_valid = accept && (state_q == S_PAYLOAD);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    words_d   = words_q;
    addr_d    = addr_q;
    xor_d     = xor_q;
    asm_clear = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_HDR;
          words_d   = '0;
          xor_d     = 8'd0;
          asm_clear = 1'b1;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (len_ok(in_data)) begin
            len_d   = in_data[WCNT_W-1:0];
            state_d = S_PAYLOAD;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          if (asm_last_byte) begin
            // Address and count move on the same edge that raises mem_we, so
            // during the write mem_addr is word k and words_loaded is k+1.
            addr_d  = words_q[ADDR_W-1:0];
            words_d = words_q + 7'd1;
            if (words_d == len_q) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      xor_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      xor_q   <= xor_d;
    end
  end

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_byte_valid),
    .byte_in    (in_data),
    .last_byte  (asm_last_byte),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  assign mem_addr     = addr_q;
  assign words_loaded = words_q;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  // The core runs only when idle after reset or after a good load.
  assign cpu_hold     = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Drives framed byte streams into imem_loader. Expected IMEM writes are
//   derived from the frame contents (little-endian packing of the payload)
//   and checked by a compare process on every mem_we cycle; frame outcome is
//   derived from the length rule and the XOR of the payload.
// -----------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [6:0]        words_loaded;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;
  logic [7:0]  pay[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] mem_img[64];
  int          cmp_a;
  logic [31:0] cmp_d;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word i of the frame is payload bytes 4i..4i+3, LSB first.
  task automatic expect_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = 32'd0;
      for (int k = 0; k < 4; k++) w = w | (32'(pay[4*i+k]) << (8*k));
      exp_addr.push_back(i);
      exp_data.push_back(w);
    end
  endtask

  function automatic logic [7:0] model_xor();
    logic [7:0] x;
    x = 8'd0;
    foreach (pay[i]) x = x ^ pay[i];
    return x;
  endfunction

  // Compare process: every write must be the next expected word, in order.
  always @(negedge clk) begin
    if (!rst) begin
      check("done_and_error", 32'(done && error), 32'd0);
      if (mem_we) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_mem_we", 32'(mem_addr), 32'hffffffff);
        end else begin
          cmp_a = exp_addr.pop_front();
          cmp_d = exp_data.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(cmp_a));
          check("mem_wdata", mem_wdata, cmp_d);
          check("words_loaded_at_we", 32'(words_loaded), 32'(cmp_a + 1));
        end
        mem_img[mem_addr] = mem_wdata;
        wr_count++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        in_data = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},     32'(in_ready),     32'd0);
    check({tag, "_mem_we"},       32'(mem_we),       32'd0);
    check({tag, "_mem_addr"},     32'(mem_addr),     32'd0);
    check({tag, "_mem_wdata"},    mem_wdata,         32'd0);
    check({tag, "_cpu_hold"},     32'(cpu_hold),     32'd0);
    check({tag, "_done"},         32'(done),         32'd0);
    check({tag, "_error"},        32'(error),        32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // One frame: optional start, header, payload (from pay), checksum.
  // flip != 0 corrupts the checksum byte; start_at >= 0 pulses start
  // before that payload byte to show it is ignored.
  task automatic run_frame(input int n, input logic [7:0] flip, input bit gaps,
                           input int start_at, input bit do_start,
                           input bit rnd);
    int wr0;
    bit good_len;
    if (do_start) pulse_start();
    good_len = (n >= 1) && (n <= 64);
    if (rnd) begin
      pay.delete();
      if (good_len) for (int i = 0; i < 4*n; i++) pay.push_back(8'($urandom));
    end
    if (good_len) expect_words(n);
    wr0 = wr_count;
    send_byte(8'(n), gaps);
    if (!good_len) begin
      check("hdr_err_error",    32'(error),    32'd1);
      check("hdr_err_done",     32'(done),     32'd0);
      check("hdr_err_cpu_hold", 32'(cpu_hold), 32'd1);
      check("hdr_err_in_ready", 32'(in_ready), 32'd0);
      repeat (4) @(negedge clk);
      check("hdr_err_no_writes", 32'(wr_count - wr0), 32'd0);
      return;
    end
    foreach (pay[i]) begin
      if (i == start_at) pulse_start();
      send_byte(pay[i], gaps);
    end
    send_byte(model_xor() ^ flip, gaps);
    check("frame_done",         32'(done),         32'(flip == 8'd0));
    check("frame_error",        32'(error),        32'(flip != 8'd0));
    check("frame_cpu_hold",     32'(cpu_hold),     32'(flip != 8'd0));
    check("frame_in_ready",     32'(in_ready),     32'd0);
    check("frame_words_loaded", 32'(words_loaded), 32'(n));
    check("frame_write_count",  32'(wr_count - wr0), 32'(n));
    check("frame_pending",      32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed frame with a known image.
    pay = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00};
    check("model_xor_pin", 32'(model_xor()), 32'h11);
    run_frame(2, 8'h00, 1'b0, -1, 1'b1, 1'b0);
    check("img0_pin", mem_img[0], 32'h00000093);
    check("img1_pin", mem_img[1], 32'h00108113);

    // Same frame with CHK = 12: words still land, frame flagged bad.
    mem_img[0] = 32'd0; mem_img[1] = 32'd0;
    run_frame(2, 8'h03, 1'b0, -1, 1'b1, 1'b0);
    check("bad_chk_img1", mem_img[1], 32'h00108113);

    // Illegal lengths.
    run_frame(0,  8'h00, 1'b0, -1, 1'b1, 1'b1);
    run_frame(65, 8'h00, 1'b0, -1, 1'b1, 1'b1);

    // Full-depth frame with random in_valid gaps.
    run_frame(64, 8'h00, 1'b1, -1, 1'b1, 1'b1);

    // Reset after 5 payload bytes of a 3-word frame: only word 0 is written.
    pulse_start();
    pay.delete();
    for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
    w0 = {pay[3], pay[2], pay[1], pay[0]};
    exp_addr.push_back(0);
    exp_data.push_back(w0);
    send_byte(8'd3, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(pay[i], 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    @(negedge clk);
    check("abort_pending", 32'(exp_addr.size()), 32'd0);
    check("abort_img0",    mem_img[0], w0);
    run_frame(5, 8'h00, 1'b1, -1, 1'b1, 1'b1);

    // start mid-payload is ignored; start in DONE restarts into HDR.
    run_frame(8, 8'h00, 1'b1, 6, 1'b1, 1'b1);
    pulse_start();
    check("restart_done",     32'(done),         32'd0);
    check("restart_cpu_hold", 32'(cpu_hold),     32'd1);
    check("restart_in_ready", 32'(in_ready),     32'd1);
    check("restart_words",    32'(words_loaded), 32'd0);
    run_frame(4, 8'h00, 1'b0, -1, 1'b0, 1'b1);

    // Random frames, some with corrupted checksums, then restart from ERR.
    repeat (5) begin
      int n;
      logic [7:0] flip;
      n = $urandom_range(1, 64);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(n, flip, 1'($urandom_range(0, 1)), -1, 1'b1, 1'b1);
    end
    run_frame(1, 8'h00, 1'b1, -1, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
